vga_scan_driver: RTL and testbench

//  Drives the VGA scan and consumes pixel-hit renderers. Generates the (x, y) scan coordinates fed to

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_scan_driver_if.sv | 25 ++
 rtl/vga_wrap_counter.sv | 36 +++
 rtl/vga_scan_driver.sv | 126 ++++++++++++
 tb/tb_vga_scan_driver.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (800x600@72Hz from a 50 MHz pixel clock), colour type
// and helpers used by the scan driver and its counters.
package vga_pkg;

  localparam int CNT_W     = 11;
  localparam int CNT_LIMIT = 2048;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 56;
  localparam int H_SYNC_DEF   = 120;
  localparam int H_BP_DEF     = 64;
  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 37;
  localparam int V_SYNC_DEF   = 6;
  localparam int V_BP_DEF     = 23;
`ifdef VGA_BLINK_EN
  localparam int BLINK_LOG2_DEF = 5;
`endif

  typedef logic [8:0] rgb9_t;

  function automatic int line_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic [2:0] rgb_r(rgb9_t c);
    return c[8:6];
  endfunction

  function automatic logic [2:0] rgb_g(rgb9_t c);
    return c[5:3];
  endfunction

  function automatic logic [2:0] rgb_b(rgb9_t c);
    return c[2:0];
  endfunction

endpackage

// File: rtl/vga_scan_driver_if.sv
// Scan-driver bundle: renderer side (x, y, hit, colours) plus the DAC outputs.
interface vga_scan_driver_if;
  logic              hit;
  vga_pkg::rgb9_t    fg_color;
  vga_pkg::rgb9_t    bg_color;
  logic [10:0]       x;
  logic [10:0]       y;
  logic              active;
  logic              frame_start;
  logic [2:0]        vga_r;
  logic [2:0]        vga_g;
  logic [2:0]        vga_b;
  logic              hsync;
  logic              vsync;

  modport master (
    input  hit, fg_color, bg_color,
    output x, y, active, frame_start, vga_r, vga_g, vga_b, hsync, vsync
  );

  modport slave (
    output hit, fg_color, bg_color,
    input  x, y, active, frame_start, vga_r, vga_g, vga_b, hsync, vsync
  );
endinterface

// File: rtl/vga_wrap_counter.sv
// Enabled counter that wraps to zero after MAX; wrap pulses while en is high on the terminal count.
module vga_wrap_counter
#(
  parameter int WIDTH = 11,
  parameter int MAX   = 1039
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == MAX_C) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = en && (count_q == MAX_C);

endmodule

// File: rtl/vga_scan_driver.sv
// VGA scan generator with registered RGB/sync outputs and per-frame colour latching.
// Optional foreground blink is built when VGA_BLINK_EN is defined.
module vga_scan_driver
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b1
`ifdef VGA_BLINK_EN
  , parameter int BLINK_LOG2 = BLINK_LOG2_DEF
`endif
) (
  input  logic               clk,
  input  logic               rst,
  vga_scan_driver_if.master  bus
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_size_check
    $error("vga_scan_driver: H_TOTAL/V_TOTAL do not fit the 11-bit scan counters");
  end

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] x_cnt, y_cnt;
  logic             x_wrap, y_wrap;
  logic             active, frame_start;
  rgb9_t            fg_q, fg_d, bg_q, bg_d, rgb_q, rgb_d, fg_sel;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;

  vga_wrap_counter #(.WIDTH(CNT_W), .MAX(H_TOTAL - 1)) u_x_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (x_cnt),
    .wrap  (x_wrap)
  );

  vga_wrap_counter #(.WIDTH(CNT_W), .MAX(V_TOTAL - 1)) u_y_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (x_wrap),
    .count (y_cnt),
    .wrap  (y_wrap)
  );

`ifdef VGA_BLINK_EN
  localparam int BLINK_W = BLINK_LOG2 + 1;
  logic [BLINK_W-1:0] blink_q, blink_d;

  // Counts completed frames, so the first frame after reset is always phase 0.
  always_comb begin
    blink_d = blink_q;
    if (x_wrap && y_wrap) begin
      blink_d = blink_q + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  logic unused_y_wrap;
  assign unused_y_wrap = y_wrap;
`endif

  // The frame_start pixel already uses the newly latched colours, so a frame is never split.
  always_comb begin
    active      = (x_cnt < H_ACT_C) && (y_cnt < V_ACT_C);
    frame_start = (x_cnt == '0) && (y_cnt == '0);
    fg_d        = frame_start ? bus.fg_color : fg_q;
    bg_d        = frame_start ? bus.bg_color : bg_q;
`ifdef VGA_BLINK_EN
    fg_sel      = blink_q[BLINK_W-1] ? bg_d : fg_d;
`else
    fg_sel      = fg_d;
`endif
    rgb_d       = active ? (bus.hit ? fg_sel : bg_d) : '0;
    hsync_d     = ((x_cnt >= HS_FIRST) && (x_cnt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_d     = ((y_cnt >= VS_FIRST) && (y_cnt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fg_q    <= '0;
      bg_q    <= '0;
      rgb_q   <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else begin
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign bus.x           = x_cnt;
  assign bus.y           = y_cnt;
  assign bus.active      = active;
  assign bus.frame_start = frame_start;
  assign bus.vga_r       = rgb_r(rgb_q);
  assign bus.vga_g       = rgb_g(rgb_q);
  assign bus.vga_b       = rgb_b(rgb_q);
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Scoreboard bench for vga_scan_driver on a shrunken 15x11 timing so several frames fit.
module tb_vga_scan_driver;
  import vga_pkg::*;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2, HT = 15;
  localparam int VA = 6, VFP = 2, VS = 2, VBP = 1, VT = 11;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        act;
    logic        fs;
    logic [8:0]  rgb;
    logic        hs;
    logic        vs;
  } obs_t;

  localparam obs_t RESET_OBS = '{x: 11'd0, y: 11'd0, act: 1'b1, fs: 1'b1,
                                 rgb: 9'h000, hs: 1'b0, vs: 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_scan_driver_if bus();

  vga_scan_driver #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .SYNC_POL (1'b1)
`ifdef VGA_BLINK_EN
    , .BLINK_LOG2 (1)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    checks = 0;
  int    errors = 0;
  obs_t  exp_q[$];
  int    mx, my, fcnt;
  rgb9_t fgm, bgm;

  function automatic obs_t sample();
    obs_t o;
    o.x   = bus.x;
    o.y   = bus.y;
    o.act = bus.active;
    o.fs  = bus.frame_start;
    o.rgb = {bus.vga_r, bus.vga_g, bus.vga_b};
    o.hs  = bus.hsync;
    o.vs  = bus.vsync;
    return o;
  endfunction

  task automatic chk_obs(input string name, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d act=%0b fs=%0b rgb=%03h hs=%0b vs=%0b, expected x=%0d y=%0d act=%0b fs=%0b rgb=%03h hs=%0b vs=%0b",
               name, a.x, a.y, a.act, a.fs, a.rgb, a.hs, a.vs,
               e.x, e.y, e.act, e.fs, e.rgb, e.hs, e.vs);
    end
  endtask

  task automatic chk_val(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, a, e);
    end else begin
      $display("check %s: %0d", name, a);
    end
  endtask

  // One pixel of stimulus: drive inputs for the current model coordinate, push the
  // expected post-edge observation, advance the model, then wait for the next negedge.
  task automatic step(input int phase);
    obs_t  e;
    logic  h, fs, act, blink;
    rgb9_t fg, bg;
    if (phase == 0) begin
      fg = (fcnt == 0 && (my < 3 || (my == 3 && mx < 4))) ? 9'h1C0 : 9'h038;
      bg = 9'h007;
      h  = !(fcnt == 0 && mx == 3 && my == 3);
    end else begin
      fg = 9'h0AA;
      bg = 9'h155;
      h  = ((mx + my) % 2) == 1;
    end
    bus.hit      = h;
    bus.fg_color = fg;
    bus.bg_color = bg;
    fs  = (mx == 0) && (my == 0);
    if (fs) begin
      fgm = fg;
      bgm = bg;
    end
    act = (mx < HA) && (my < VA);
`ifdef VGA_BLINK_EN
    blink = (fcnt % 4) >= 2;
`else
    blink = 1'b0;
`endif
    e.rgb = !act ? 9'h000 : (h ? (blink ? bgm : fgm) : bgm);
    e.hs  = (mx >= HA + HFP) && (mx < HA + HFP + HS);
    e.vs  = (my >= VA + VFP) && (my < VA + VFP + VS);
    mx++;
    if (mx == HT) begin
      mx = 0;
      my++;
      if (my == VT) begin
        my = 0;
        fcnt++;
      end
    end
    e.x   = 11'(mx);
    e.y   = 11'(my);
    e.act = (mx < HA) && (my < VA);
    e.fs  = (mx == 0) && (my == 0);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: the DUT presents a new pixel every edge; compare it against the queue head.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_obs("pixel", sample(), e);
        if (e.fs) $display("frame boundary at %0t", $time);
      end
    end
  end

  initial begin
    int guard;
    bus.hit      = 1'b0;
    bus.fg_color = '0;
    bus.bg_color = '0;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_obs("reset_hold", sample(), RESET_OBS);

    rst = 1'b1;
    mx = 0; my = 0; fcnt = 0; fgm = '0; bgm = '0;
    step(0);
    chk_val("first_x_after_release", int'(bus.x), 1);

    guard = 0;
    while (!(fcnt == 5 && my == 2 && mx == 5) && guard < 6 * FRAME) begin
      step(0);
      guard++;
    end
    chk_val("reached_mid_frame", guard, 5 * FRAME + 2 * HT + 5 - 1);

    rst = 1'b0;
    #1;
    chk_obs("mid_frame_reset", sample(), RESET_OBS);
    repeat (2) @(negedge clk);
    chk_obs("mid_frame_reset_held", sample(), RESET_OBS);

    rst = 1'b1;
    mx = 0; my = 0; fcnt = 0; fgm = '0; bgm = '0;
    for (int i = 0; i < FRAME + 20; i++) step(1);

    @(posedge clk);
    #2;
    chk_val("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
